// File: rtl/audio_clk_gen.sv
// Audio clock generator: BCLK/LRCLK pair plus single-cycle strobes derived from the system clock.
// The divisor and slot length are shadowed and only take effect on frame boundaries.
module audio_clk_gen #(
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned SLOT_W        = 6,
  parameter int unsigned DEF_BCLK_DIV  = 12,
  parameter int unsigned DEF_SLOT_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  cfg_bclk_div,
  input  logic [SLOT_W-1:0] cfg_slot_bits,
  input  logic              cfg_load,
  output logic              cfg_busy,
  output logic              bclk,
  output logic              lrclk,
  output logic              bclk_rise,
  output logic              bclk_fall,
  output logic              frame_start,
  output logic              running
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_phase, w_phase_nxt;
  logic [SLOT_W-1:0] r_bit, w_bit_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt, r_sh_div, w_sh_div_nxt;
  logic [SLOT_W-1:0] r_slot, w_slot_nxt, r_sh_slot, w_sh_slot_nxt;
  logic              r_pend, w_pend_nxt;
  logic              r_bclk, w_bclk_nxt;
  logic              r_lrclk, w_lrclk_nxt;
  logic              r_rise, w_rise_nxt;
  logic              r_fall, w_fall_nxt;
  logic              r_fs, w_fs_nxt;
  logic              r_running, w_running_nxt;

  logic [DIV_W-1:0]  w_half_lo;
  logic [DIV_W-1:0]  w_phase_inc;
  logic [DIV_W-1:0]  w_clamp_div;
  logic [SLOT_W-1:0] w_clamp_slot;
  logic              w_last_phase, w_last_bit, w_wrap, w_boundary;
  logic              w_start, w_apply;

  // Low phase is ceil(D/2) cycles; computed without widening so D = 2^DIV_W-1 cannot overflow.
  assign w_half_lo    = (r_div >> 1) + DIV_W'(r_div[0]);
  assign w_last_phase = (r_phase == r_div - DIV_W'(1));
  assign w_last_bit   = (r_bit == r_slot - SLOT_W'(1));
  assign w_wrap       = w_last_phase && w_last_bit;
  assign w_boundary   = w_wrap && r_lrclk;
  assign w_phase_inc  = w_last_phase ? '0 : r_phase + DIV_W'(1);
  assign w_clamp_div  = (r_sh_div < DIV_W'(2)) ? DIV_W'(2) : r_sh_div;
  assign w_clamp_slot = (r_sh_slot == '0) ? SLOT_W'(1) : r_sh_slot;

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_bit_nxt     = r_bit;
    w_div_nxt     = r_div;
    w_slot_nxt    = r_slot;
    w_sh_div_nxt  = r_sh_div;
    w_sh_slot_nxt = r_sh_slot;
    w_pend_nxt    = r_pend;
    w_bclk_nxt    = 1'b0;
    w_lrclk_nxt   = 1'b0;
    w_rise_nxt    = 1'b0;
    w_fall_nxt    = 1'b0;
    w_fs_nxt      = 1'b0;
    w_running_nxt = 1'b0;
    w_start       = 1'b0;
    w_apply       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_apply = r_pend;
        w_start = en;
      end
      ST_RUN: begin
        if (w_boundary) begin
          // en only matters here; a stop lands cleanly after the right half completes.
          w_start = en;
          w_apply = en && r_pend;
          if (!en) begin
            w_state_nxt = ST_IDLE;
            w_phase_nxt = '0;
            w_bit_nxt   = '0;
          end
        end else begin
          w_running_nxt = 1'b1;
          w_phase_nxt   = w_phase_inc;
          if (w_last_phase)
            w_bit_nxt = w_last_bit ? '0 : r_bit + SLOT_W'(1);
          w_lrclk_nxt = w_wrap ? ~r_lrclk : r_lrclk;
          w_bclk_nxt  = (w_phase_inc >= w_half_lo);
          w_fall_nxt  = w_last_phase;
          w_rise_nxt  = (w_phase_inc == w_half_lo);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_start) begin
      w_state_nxt   = ST_RUN;
      w_phase_nxt   = '0;
      w_bit_nxt     = '0;
      w_fall_nxt    = 1'b1;
      w_fs_nxt      = 1'b1;
      w_running_nxt = 1'b1;
    end

    if (w_apply) begin
      w_div_nxt  = w_clamp_div;
      w_slot_nxt = w_clamp_slot;
      w_pend_nxt = 1'b0;
    end

    // A load coinciding with an apply is kept pending for the following frame.
    if (cfg_load) begin
      w_sh_div_nxt  = cfg_bclk_div;
      w_sh_slot_nxt = cfg_slot_bits;
      w_pend_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_bit     <= '0;
      r_div     <= DIV_W'(DEF_BCLK_DIV);
      r_slot    <= SLOT_W'(DEF_SLOT_BITS);
      r_sh_div  <= DIV_W'(DEF_BCLK_DIV);
      r_sh_slot <= SLOT_W'(DEF_SLOT_BITS);
      r_pend    <= 1'b0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_fs      <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_bit     <= w_bit_nxt;
      r_div     <= w_div_nxt;
      r_slot    <= w_slot_nxt;
      r_sh_div  <= w_sh_div_nxt;
      r_sh_slot <= w_sh_slot_nxt;
      r_pend    <= w_pend_nxt;
      r_bclk    <= w_bclk_nxt;
      r_lrclk   <= w_lrclk_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_fs      <= w_fs_nxt;
      r_running <= w_running_nxt;
    end
  end

  assign cfg_busy    = r_pend;
  assign bclk        = r_bclk;
  assign lrclk       = r_lrclk;
  assign bclk_rise   = r_rise;
  assign bclk_fall   = r_fall;
  assign frame_start = r_fs;
  assign running     = r_running;

endmodule

// File: doc/audio_clk_gen.md
# audio_clk_gen

Parametrised audio clock generator that produces a BCLK/LRCLK pair and the matching single-cycle strobes from the system clock.
- BCLK divisor and slot length are runtime-programmable, with shadowed updates applied only on frame boundaries.
- Odd divisors are supported.
- Start/stop is clean, with no truncated frames.
- The block sits between the system clock and the I2S serialiser/deserialiser and codec pins, and replaces fixed-ratio dividers in the audio path.

## Interface
Parameters:
- DIV_W, 16, width of BCLK divisor field/counter
- SLOT_W, 6, width of bits-per-half-frame field/counter
- DEF_BCLK_DIV, 12, reset value of active divisor D (system clocks per BCLK period)
- DEF_SLOT_BITS, 32, reset value of active slot length S (BCLK periods per LRCLK half)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset rst, synchronous, active-high
- en  in  1  run request
- cfg_bclk_div  in  DIV_W  new D, sampled with cfg_load
- cfg_slot_bits  in  SLOT_W  new S, sampled with cfg_load
- cfg_load  in  1  capture cfg_* into shadow registers
- cfg_busy  out  1  shadow pending, not yet applied
- bclk  out  1  bit clock, registered
- lrclk  out  1  word select: 0 = left half, 1 = right half
- bclk_rise  out  1  high in first cycle bclk is 1
- bclk_fall  out  1  high in first cycle of each BCLK period (low phase)
- frame_start  out  1  high with the bclk_fall that opens a left half
- running  out  1  generator active

## Operation
- **States**
  - IDLE: all clock outputs 0, no strobes.
  - RUN: generating frames.
- **BCLK period of D cycles**
  - Low for L = ceil(D/2) cycles, then high for H = floor(D/2) cycles.
  - Internal phase counter runs 0..D-1 and wraps.
- **Bit counter**
  - Advances on each bclk_fall and runs 0..S-1.
  - On wrap, lrclk toggles in the same cycle as that bclk_fall.
  - Frame length = 2·S·D clocks.
- **Start**
  - In IDLE with en=1 sampled at edge E, the cycle after E shows: frame_start=1, bclk_fall=1, bclk=0, lrclk=0, running=1.
- **Stop**
  - en is examined only at frame boundaries; deasserting en mid-frame has no effect until the boundary.
  - If en=0 at the edge that would produce the next frame_start, the block enters IDLE instead: bclk=0, lrclk=0, running=0, no strobes.
- **Config capture**
  - cfg_load sampled at edge E writes the shadow registers and sets pending.
  - cfg_busy=1 from cycle E+1.
  - A cfg_load while pending overwrites the shadow; last write wins.
- **Config apply**
  - In RUN: at the first frame_start generated at edge E+1 or later, that frame uses the new D/S, and cfg_busy clears in the same cycle.
  - In IDLE: applied at edge E+1, so cfg_busy is high for exactly 1 cycle; an en start at E+1 uses the new values.
  - A frame in progress is never altered.
- **Clamping**
  - D < 2 applies as 2.
  - S < 1 applies as 1.
  - Clamping happens on apply.
  - Maximum D = 2^DIV_W−1; maximum S = 2^SLOT_W−1.
- **Simultaneous cfg_load and boundary edge**
  - The load is captured, but the boundary at that edge uses the old values.
  - The load applies at the following frame.

## Timing
- **Reset**
  - Output values: bclk=0, lrclk=0, bclk_rise=0, bclk_fall=0, frame_start=0, running=0, cfg_busy=0.
  - Internal state: active D=DEF_BCLK_DIV, S=DEF_SLOT_BITS, counters 0, shadow pending discarded.
  - rst takes priority over en and cfg_load.
  - Reset mid-frame gives reset values in the next cycle.
- **Outputs and latency**
  - All outputs are registered and glitch-free.
  - Start latency: 1 cycle from en sampled to frame_start.
- **Strobe alignment**
  - bclk_fall coincides with the 1→0 (or initial) bclk transition.
  - bclk_rise coincides with 0→1.
  - With D=2, the two strobes alternate every cycle.
- **running** is high from the first frame_start cycle through the last cycle of the final frame.

## Test plan
- **Defaults:** after rst, en=1 at cycle 0 → frame_start at cycle 1; bclk 6 low/6 high; lrclk toggles every 384 clocks; frame_start period 768.
- **Odd divisor:** idle cfg_load D=5, S=2, then en=1 → bclk 3 low/2 high; lrclk 0 for 10 clocks, then 1 for 10; frame 20 clocks.
- **Reconfig mid-frame:** running D=4, S=2; cfg_load D=6 at frame cycle 5 → current frame completes in 16 clocks, next frame is 24 clocks; cfg_busy high from cycle 6 until the new frame_start cycle.
- **Stop/restart:** en=0 mid right half → frame completes, then bclk=0, lrclk=0, running=0, no strobes; en=1 → frame_start next cycle.
- **Clamp:** idle cfg_load D=0, S=0 → bclk toggles every cycle; lrclk period 4 clocks; bclk_rise/bclk_fall alternate.
- **Reset mid-frame:** 1-cycle rst in RUN with cfg_busy=1 → next cycle all outputs at reset values, cfg_busy=0; restart runs at D=12, S=32.
